// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the 4x4 hex keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Indexed by {row, col}; entry 0 is the top-left key.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    // Active-low column drive, one bit low per column index.
    localparam logic [3:0][3:0] COL_DRIVE = {
        4'b0111, 4'b1011, 4'b1101, 4'b1110
    };

    function automatic logic [1:0] row_index(input logic [3:0] rows_low);
        logic [1:0] idx;
        idx = 2'd0;
        if (rows_low[3]) idx = 2'd3;
        if (rows_low[2]) idx = 2'd2;
        if (rows_low[1]) idx = 2'd1;
        if (rows_low[0]) idx = 2'd0;
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// rtl/scan_tick.sv - free-running divider producing a one-clk scan tick
module scan_tick #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - column-scanning keypad reader with debounce and hex entry shift register
module keypad_scanner #(
    parameter int SCAN_DIV  = 100000,
    parameter int DEB_TICKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row_n,
    input  logic        clear,
    output logic [3:0]  col_n,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [31:0] entry
);

    import keypad_pkg::*;

    localparam int CNT_W = $clog2(DEB_TICKS + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_TICKS);

    logic [3:0]       row_meta;
    logic [3:0]       rows_s;
    logic             tick;
    state_t           state, state_n;
    logic [1:0]       col_idx, col_idx_n;
    logic [1:0]       row_idx, row_idx_n;
    logic [CNT_W-1:0] deb_cnt, deb_cnt_n;
    logic [CNT_W-1:0] rel_cnt, rel_cnt_n;
    logic [3:0]       key_code_n;
    logic             key_valid_n;
    logic             key_down_n;
    logic [3:0]       rows_low;
    logic             press_ok;
    logic [1:0]       press_row;

    scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Idle rows read high, so the synchronizer resets to "no key".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta <= 4'hF;
            rows_s   <= 4'hF;
        end else begin
            row_meta <= row_n;
            rows_s   <= row_meta;
        end
    end

    // Ghosted or empty patterns never qualify as a press.
    assign rows_low  = ~rows_s;
    assign press_ok  = $onehot(rows_low);
    assign press_row = row_index(rows_low);
    assign col_n     = COL_DRIVE[col_idx];

    always_comb begin
        state_n     = state;
        col_idx_n   = col_idx;
        row_idx_n   = row_idx;
        deb_cnt_n   = deb_cnt;
        rel_cnt_n   = rel_cnt;
        key_code_n  = key_code;
        key_down_n  = key_down;
        key_valid_n = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (press_ok) begin
                        row_idx_n = press_row;
                        if (DEB_TICKS == 1) begin
                            key_code_n  = KEY_MAP[{press_row, col_idx}];
                            key_valid_n = 1'b1;
                            key_down_n  = 1'b1;
                            deb_cnt_n   = '0;
                            rel_cnt_n   = '0;
                            state_n     = HELD;
                        end else begin
                            deb_cnt_n = CNT_W'(1);
                            state_n   = DEBOUNCE;
                        end
                    end else begin
                        col_idx_n = col_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (press_ok && (press_row == row_idx)) begin
                        if ((deb_cnt + CNT_W'(1)) == DEB_LAST) begin
                            key_code_n  = KEY_MAP[{row_idx, col_idx}];
                            key_valid_n = 1'b1;
                            key_down_n  = 1'b1;
                            deb_cnt_n   = '0;
                            rel_cnt_n   = '0;
                            state_n     = HELD;
                        end else begin
                            deb_cnt_n = deb_cnt + CNT_W'(1);
                        end
                    end else begin
                        // Rescan the same column so a bouncing key is retried promptly.
                        deb_cnt_n = '0;
                        state_n   = SCAN;
                    end
                end
                HELD: begin
                    if (rows_s == 4'hF) begin
                        if ((rel_cnt + CNT_W'(1)) == DEB_LAST) begin
                            key_down_n = 1'b0;
                            rel_cnt_n  = '0;
                            col_idx_n  = col_idx + 2'd1;
                            state_n    = SCAN;
                        end else begin
                            rel_cnt_n = rel_cnt + CNT_W'(1);
                        end
                    end else begin
                        rel_cnt_n = '0;
                    end
                end
                default: begin
                    state_n = SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_n;
            col_idx   <= col_idx_n;
            row_idx   <= row_idx_n;
            deb_cnt   <= deb_cnt_n;
            rel_cnt   <= rel_cnt_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            key_down  <= key_down_n;
        end
    end

    // Clear takes priority so a coincident key is dropped from the entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry <= 32'h0;
        end else if (clear) begin
            entry <= 32'h0;
        end else if (key_valid) begin
            entry <= {entry[27:0], key_code};
        end
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display path: scans a 4x4 hex keypad (Pmod KYPD) by driving one column low at a time and reading active-low rows.
- Debounces presses, converts each to a 4-bit hex code, and emits a one-cycle valid strobe.
- Shifts each accepted key into a 32-bit entry register that can drive the display controller's seg bus directly.
- Used on the register-file lab board for hex data entry.

Parameters:
- SCAN_DIV, 100000, clk cycles per scan tick (1 kHz at 100 MHz); legal range >= 2.
- DEB_TICKS, 4, consecutive matching scan ticks required to accept a press or a release; legal range >= 1.

Ports:
- clk  input  1  board 100 MHz clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high; forces all state and outputs to reset values.
- row_n  input  4  keypad rows, active-low, asynchronous; bit 0 = top row.
- clear  input  1  synchronous clear of entry; sampled on clk.
- col_n  output  4  keypad column drive, active-low, exactly one bit low; bit 0 = left column.
- key_code  output  4  hex value of the last accepted key; holds between presses.
- key_valid  output  1  one-clk pulse when a press is accepted.
- key_down  output  1  high from acceptance until release is accepted.
- entry  output  32  last eight keys, newest in bits [3:0].

Behaviour:
- Reset values: col_n=4'b1110, key_code=0, key_valid=0, key_down=0, entry=0, FSM=SCAN, all counters 0. Reset asserted mid-debounce or mid-hold aborts that operation with no key_valid.
- row_n passes through a 2-flop synchronizer before any use. rows_s is the synchronized value.
- Tick generator:
  - Counter runs 0..SCAN_DIV-1 and wraps.
  - tick = 1 for one clk when the count equals SCAN_DIV-1.
  - FSM decisions occur only on tick cycles.
- Valid press: rows_s has exactly one bit low. Zero bits low or two or more bits low is treated as no key; ghosting is never reported.
- FSM SCAN, on tick:
  - If there is a valid press, latch the column index and the row index, set deb_cnt=1, and go to DEBOUNCE. If DEB_TICKS=1, accept the press on this same tick.
  - Otherwise, advance the column index modulo 4 (3 wraps to 0). col_n updates on the clk after the tick, so each column settles for a full tick period before it is sampled.
- FSM DEBOUNCE, on tick:
  - The column is held.
  - If the same single row is low, increment deb_cnt.
  - If deb_cnt reaches DEB_TICKS, accept the press. Acceptance means: key_code is loaded from the map, key_valid pulses on the next clk, key_down is set, state goes to HELD, and deb_cnt is cleared.
  - On any mismatch (different row, no row, or multiple rows), return to SCAN on the same column with no output.
- FSM HELD, on tick:
  - The column is held.
  - If all rows are high, increment rel_cnt. Any low row resets rel_cnt to 0.
  - When rel_cnt reaches DEB_TICKS: clear key_down, go to SCAN, and advance the column.
  - No repeat strobes while a key is held.
- Key map as (row,col) -> code:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: 0 F E D
- Entry register:
  - On key_valid: entry <= {entry[27:0], key_code}. Older nibbles shift out of bits [31:28] and are discarded.
  - clear=1: entry <= 0.
  - clear and key_valid in the same cycle: clear wins and the key is lost. key_code still updates.
- Latency: from a stable press to key_valid is at most (4+DEB_TICKS)*SCAN_DIV + 4 clks.

Decomposition:
- Shared package keypad_pkg:
  - state encoding constants SCAN/DEBOUNCE/HELD (2-bit);
  - 16-entry KEY_MAP constant indexed by {row,col};
  - one-hot-low column decode constants.
- One sub-module, scan_tick: SCAN_DIV counter producing a one-clk tick pulse, with asynchronous active-high reset.
- The FSM, debounce/release counters, synchronizer, and entry register stay in keypad_scanner.

Test Plan (SCAN_DIV=4, DEB_TICKS=3 unless stated):
- Reset check: assert reset mid-run -> col_n=4'b1110, entry=0, key_down=0 immediately, asynchronously. Release reset, no keys pressed -> col_n cycles 1110,1101,1011,0111,1110, with each value lasting 4 clks.
- Clean press: model the keypad so that row 1 is low only while col_n=4'b1011; press "6" -> exactly one key_valid, key_code=4'h6, entry=32'h0000_0006, key_down=1. Release -> key_down=0 after 3 quiet ticks.
- Bounce rejection: toggle the "A" press every tick for 10 ticks, then hold stably -> exactly one key_valid with code 4'hA; no strobe during the bounce. Toggle during HELD -> no extra strobe and key_down stays 1.
- Entry shift: press 1,2,3,4,5,6,7,8,9 in sequence -> entry=32'h2345_6789. Assert clear -> entry=0. Clear coincident with key_valid -> entry=0 and key_code holds the new code.
- Ghosting and boundaries: two rows low in the same column -> no key_valid. Press "D" (row 3, col 3) -> code 4'hD, covering column wrap. Press "0" -> code 4'h0. Rerun one press with DEB_TICKS=1 -> key_valid on the first detecting tick.
- Reset mid-operation: assert reset during DEBOUNCE after 2 of 3 ticks -> no key_valid, FSM=SCAN. Assert reset during HELD -> key_down=0 at once and entry=0.
